// File: rtl/vga_pkg.sv
// Timing constants and RGB565 field layout for the 640x480@60 Hz display stage.
// Shared by the sync counter and the output stage.
package vga_pkg;

   localparam int H_ACTIVE   = 640;
   localparam int H_FP       = 16;
   localparam int H_SYNC     = 96;
   localparam int H_BP       = 48;
   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE   = 480;
   localparam int V_FP       = 10;
   localparam int V_SYNC     = 2;
   localparam int V_BP       = 33;
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int FRAME_LINE = 492;
   localparam int STRETCH    = 4;

   localparam int HS_START   = H_ACTIVE + H_FP;
   localparam int HS_END     = HS_START + H_SYNC - 1;
   localparam int VS_START   = V_ACTIVE + V_FP;
   localparam int VS_END     = VS_START + V_SYNC - 1;

   localparam int CNT_W      = 10;

   // RGB565 bit positions inside a pixel word after the byte swap.
   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   // The row buffer delivers each pixel with its two bytes exchanged.
   function automatic logic [15:0] byte_swap(input logic [15:0] word);
      return {word[7:0], word[15:8]};
   endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Free-running horizontal/vertical raster counters for the pixel domain.
// The vertical counter advances only on the last cycle of each line.
module vga_sync_counter #(
   parameter int H_TOTAL = vga_pkg::H_TOTAL,
   parameter int V_TOTAL = vga_pkg::V_TOTAL,
   parameter int CNT_W   = vga_pkg::CNT_W
) (
   input  logic             clk_25M,
   input  logic             rst_25M,
   output logic [CNT_W-1:0] h,
   output logic [CNT_W-1:0] v,
   output logic             line_end
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   assign line_end = (h == H_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; the reset is synchronous, checked only inside the clocked block.
   always_ff @(posedge clk_25M) begin
      if (rst_25M) begin
         h <= '0;
         v <= '0;
      end else if (line_end) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + ONE;
      end else begin
         h <= h + ONE;
      end
   end

endmodule

// File: rtl/vga_timing_out.sv
// VGA output stage: decodes raster position into sync/blanking, prefetch requests
// and end-of-frame, and registers byte-swapped RGB565 pixels toward the DAC.
module vga_timing_out #(
   parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
   parameter int H_FP       = vga_pkg::H_FP,
   parameter int H_SYNC     = vga_pkg::H_SYNC,
   parameter int H_BP       = vga_pkg::H_BP,
   parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
   parameter int V_FP       = vga_pkg::V_FP,
   parameter int V_SYNC     = vga_pkg::V_SYNC,
   parameter int V_BP       = vga_pkg::V_BP,
   parameter int FRAME_LINE = vga_pkg::FRAME_LINE,
   parameter int STRETCH    = vga_pkg::STRETCH
) (
   input  logic        clk_25M,
   input  logic        rst_25M,
   input  logic [15:0] pixel_data,
   output logic [9:0]  vga_h_counter,
   output logic [9:0]  vga_v_counter,
   output logic        start_frame,
   output logic        start_row,
   output logic        frame_end,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_de,
   output logic [4:0]  vga_r,
   output logic [5:0]  vga_g,
   output logic [4:0]  vga_b
);

   import vga_pkg::*;

   localparam int CW    = 10;
   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] HA       = CW'(H_ACTIVE);
   localparam logic [CW-1:0] HA_LAST  = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] VA       = CW'(V_ACTIVE);
   localparam logic [CW-1:0] VA_LAST  = CW'(V_ACTIVE - 1);
   localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [CW-1:0] FL       = CW'(FRAME_LINE);
   localparam logic [CW-1:0] SR_LAST  = CW'(H_ACTIVE + STRETCH - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);

   logic [CW-1:0] h;
   logic [CW-1:0] v;
   logic          line_end;

   vga_sync_counter #(
      .H_TOTAL (H_TOT),
      .V_TOTAL (V_TOT),
      .CNT_W   (CW)
   ) u_counter (
      .clk_25M  (clk_25M),
      .rst_25M  (rst_25M),
      .h        (h),
      .v        (v),
      .line_end (line_end)
   );

   assign vga_h_counter = h;
   assign vga_v_counter = v;

   logic        de_next;
   logic        hsync_next;
   logic        vsync_next;
   logic        start_frame_next;
   logic        start_row_next;
   logic        frame_end_next;
   logic [15:0] px;
   rgb565_t     rgb_next;

   // NOTE: every signal written here gets a default first so no path through the
   // block leaves it unassigned and no latch is inferred.
   always_comb begin
      de_next          = 1'b0;
      hsync_next       = 1'b1;
      vsync_next       = 1'b1;
      start_frame_next = 1'b0;
      start_row_next   = 1'b0;
      frame_end_next   = 1'b0;
      rgb_next         = '0;
      px               = byte_swap(pixel_data);

      de_next    = (h < HA) && (v < VA);
      hsync_next = !((h >= HS_FIRST) && (h <= HS_LAST));
      vsync_next = !((v >= VS_FIRST) && (v <= VS_LAST));

      start_frame_next = (v == FL);
      // Prefetch in the blanking of the line preceding each visible line.
      start_row_next   = (h >= HA) && (h <= SR_LAST) && ((v == V_LAST) || (v < VA_LAST));
      frame_end_next   = (h == HA_LAST) && (v == VA_LAST);

      if (de_next) begin
         rgb_next.r = px[R_MSB:R_LSB];
         rgb_next.g = px[G_MSB:G_LSB];
         rgb_next.b = px[B_MSB:B_LSB];
      end
   end

   always_ff @(posedge clk_25M) begin
      if (rst_25M) begin
         vga_de      <= 1'b0;
         vga_hsync   <= 1'b1;
         vga_vsync   <= 1'b1;
         start_frame <= 1'b0;
         start_row   <= 1'b0;
         frame_end   <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
      end else begin
         vga_de      <= de_next;
         vga_hsync   <= hsync_next;
         vga_vsync   <= vsync_next;
         start_frame <= start_frame_next;
         start_row   <= start_row_next;
         frame_end   <= frame_end_next;
         vga_r       <= rgb_next.r;
         vga_g       <= rgb_next.g;
         vga_b       <= rgb_next.b;
      end
   end

endmodule

// File: tb/tb_vga_timing_out.sv
// Scoreboard bench for vga_timing_out: a full-size instance and a shrunken-timing
// instance share stimulus; a reference model predicts every registered cycle.
module tb_vga_timing_out;

   typedef struct packed {
      int ha; int hfp; int hs; int hbp;
      int va; int vfp; int vs; int vbp;
      int fl; int st;
   } cfg_t;

   typedef struct packed {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        sf;
      logic        sr;
      logic        fe;
      logic        hs;
      logic        vs;
      logic        de;
      logic [15:0] rgb;
   } exp_t;

   localparam cfg_t CFG_D = '{640, 16, 96, 48, 480, 10, 2, 33, 492, 4};
   localparam cfg_t CFG_S = '{40, 4, 6, 6, 30, 3, 2, 5, 35, 4};
   localparam int S_HTOT = 56;
   localparam int S_VTOT = 40;
   localparam int MAX_CYC = 20000;

   logic        clk_25M = 1'b0;
   logic        rst_25M;
   logic [15:0] pixel_data;

   logic [9:0] d_h, d_v, s_h, s_v;
   logic d_sf, d_sr, d_fe, d_hs, d_vs, d_de;
   logic s_sf, s_sr, s_fe, s_hs, s_vs, s_de;
   logic [4:0] d_r, s_r, d_b, s_b;
   logic [5:0] d_g, s_g;

   always #5 clk_25M = ~clk_25M;

   vga_timing_out u_dut_std (
      .clk_25M (clk_25M), .rst_25M (rst_25M), .pixel_data (pixel_data),
      .vga_h_counter (d_h), .vga_v_counter (d_v),
      .start_frame (d_sf), .start_row (d_sr), .frame_end (d_fe),
      .vga_hsync (d_hs), .vga_vsync (d_vs), .vga_de (d_de),
      .vga_r (d_r), .vga_g (d_g), .vga_b (d_b)
   );

   vga_timing_out #(
      .H_ACTIVE (CFG_S.ha), .H_FP (CFG_S.hfp), .H_SYNC (CFG_S.hs), .H_BP (CFG_S.hbp),
      .V_ACTIVE (CFG_S.va), .V_FP (CFG_S.vfp), .V_SYNC (CFG_S.vs), .V_BP (CFG_S.vbp),
      .FRAME_LINE (CFG_S.fl), .STRETCH (CFG_S.st)
   ) u_dut_sml (
      .clk_25M (clk_25M), .rst_25M (rst_25M), .pixel_data (pixel_data),
      .vga_h_counter (s_h), .vga_v_counter (s_v),
      .start_frame (s_sf), .start_row (s_sr), .frame_end (s_fe),
      .vga_hsync (s_hs), .vga_vsync (s_vs), .vga_de (s_de),
      .vga_r (s_r), .vga_g (s_g), .vga_b (s_b)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare_out(input string pfx, input exp_t got, input exp_t exp);
      check({pfx, ".h_counter"},   32'(got.h),   32'(exp.h));
      check({pfx, ".v_counter"},   32'(got.v),   32'(exp.v));
      check({pfx, ".start_frame"}, 32'(got.sf),  32'(exp.sf));
      check({pfx, ".start_row"},   32'(got.sr),  32'(exp.sr));
      check({pfx, ".frame_end"},   32'(got.fe),  32'(exp.fe));
      check({pfx, ".hsync"},       32'(got.hs),  32'(exp.hs));
      check({pfx, ".vsync"},       32'(got.vs),  32'(exp.vs));
      check({pfx, ".de"},          32'(got.de),  32'(exp.de));
      check({pfx, ".rgb"},         32'(got.rgb), 32'(exp.rgb));
   endtask

   // Expected outputs after the coming edge, including the advanced counters.
   function automatic exp_t predict(input cfg_t c, input int h, input int v,
                                    input logic [15:0] pix, input logic rst);
      exp_t e;
      int htot, vtot;
      logic [15:0] px;
      e = '0;
      htot = c.ha + c.hfp + c.hs + c.hbp;
      vtot = c.va + c.vfp + c.vs + c.vbp;
      if (rst) begin
         e.hs = 1'b1;
         e.vs = 1'b1;
         return e;
      end
      px    = {pix[7:0], pix[15:8]};
      e.de  = (h < c.ha) && (v < c.va);
      e.rgb = e.de ? px : 16'h0000;
      e.hs  = !((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs));
      e.vs  = !((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs));
      e.sf  = (v == c.fl);
      e.sr  = (h >= c.ha) && (h < c.ha + c.st) && ((v == vtot - 1) || (v < c.va - 1));
      e.fe  = (h == c.ha - 1) && (v == c.va - 1);
      e.h   = (h == htot - 1) ? 10'd0 : 10'(h + 1);
      e.v   = (h == htot - 1) ? ((v == vtot - 1) ? 10'd0 : 10'(v + 1)) : 10'(v);
      return e;
   endfunction

   exp_t q_d[$];
   exp_t q_s[$];

   initial begin
      int   mh_d, mv_d, mh_s, mv_s;
      int   cyc, frames, post;
      int   cyc_cnt, sr_cnt, sr_rise, vs_cnt, sf_cnt;
      logic fe_seen, agg_on, rst_done, done, prev_sr;
      exp_t e, got;

      mh_d = 0; mv_d = 0; mh_s = 0; mv_s = 0;
      cyc = 0; frames = 0; post = 0;
      cyc_cnt = 0; sr_cnt = 0; sr_rise = 0; vs_cnt = 0; sf_cnt = 0;
      fe_seen = 1'b0; agg_on = 1'b1; rst_done = 1'b0; done = 1'b0; prev_sr = 1'b0;

      rst_25M    = 1'b1;
      pixel_data = 16'h0000;
      q_d.push_back(predict(CFG_D, mh_d, mv_d, pixel_data, rst_25M));
      q_s.push_back(predict(CFG_S, mh_s, mv_s, pixel_data, rst_25M));

      while (!done && cyc < MAX_CYC) begin
         @(negedge clk_25M);
         cyc++;

         got = {d_h, d_v, d_sf, d_sr, d_fe, d_hs, d_vs, d_de, {d_r, d_g, d_b}};
         check("std.queue_nonempty", 32'(q_d.size() > 0), 32'd1);
         if (q_d.size() > 0) begin
            e = q_d.pop_front();
            compare_out("std", got, e);
         end
         got = {s_h, s_v, s_sf, s_sr, s_fe, s_hs, s_vs, s_de, {s_r, s_g, s_b}};
         check("sml.queue_nonempty", 32'(q_s.size() > 0), 32'd1);
         if (q_s.size() > 0) begin
            e = q_s.pop_front();
            compare_out("sml", got, e);
         end

         // Frame-level statistics on the small instance, between frame_end pulses.
         if (agg_on) begin
            if (s_fe) begin
               if (fe_seen) begin
                  check("frame_len",        32'(cyc_cnt), 32'(S_HTOT * S_VTOT));
                  check("start_row_cycles", 32'(sr_cnt),  32'(CFG_S.va * CFG_S.st));
                  check("start_row_pulses", 32'(sr_rise), 32'(CFG_S.va));
                  check("vsync_low_cycles", 32'(vs_cnt),  32'(CFG_S.vs * S_HTOT));
                  check("start_frame_cyc",  32'(sf_cnt),  32'(S_HTOT));
                  frames++;
               end
               fe_seen = 1'b1;
               cyc_cnt = 0; sr_cnt = 0; sr_rise = 0; vs_cnt = 0; sf_cnt = 0;
            end
            cyc_cnt++;
            if (s_sr) sr_cnt++;
            if (s_sr && !prev_sr) sr_rise++;
            if (!s_vs) vs_cnt++;
            if (s_sf) sf_cnt++;
         end
         prev_sr = s_sr;

         // Stimulus: 3-cycle power-on reset, then a 1-cycle reset mid-frame.
         if (cyc < 3) begin
            rst_25M = 1'b1;
         end else if (frames >= 3 && !rst_done && mh_s == 30 && mv_s == 20) begin
            rst_25M  = 1'b1;
            rst_done = 1'b1;
            agg_on   = 1'b0;
         end else begin
            rst_25M = 1'b0;
         end
         if (rst_done) begin
            post++;
            if (post >= 300) done = 1'b1;
         end

         if (mh_s == 5 || mh_d == 5 || mh_d == 700) pixel_data = 16'h1FF8;
         else pixel_data = 16'($urandom);

         e = predict(CFG_D, mh_d, mv_d, pixel_data, rst_25M);
         q_d.push_back(e);
         mh_d = int'(e.h); mv_d = int'(e.v);
         e = predict(CFG_S, mh_s, mv_s, pixel_data, rst_25M);
         q_s.push_back(e);
         mh_s = int'(e.h); mv_s = int'(e.v);
      end

      check("run_complete", 32'(done), 32'd1);
      check("frames_seen_ge3", 32'(frames >= 3), 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
